// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer for the SRAM-like data bus (req/addr_ok/data_ok).
// One access at a time; the pipeline is held via stallreq until the bus completes it.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        pipe_advance,
    output logic        stallreq,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        misalign,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] wd_cnt_reg;
    logic             bad_align;
    logic             accept;
    logic             busy;
    logic [3:0]       strb_calc;
    logic [31:0]      wdata_calc;

    always_comb begin
        case (mem_size)
            2'b00:   bad_align = 1'b0;
            2'b01:   bad_align = mem_addr[0];
            2'b10:   bad_align = |mem_addr[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    assign accept = (state_reg == IDLE) & mem_valid & ~bad_align;
    assign busy   = (state_reg == REQ) | (state_reg == WAIT);

    // Per byte lane: strobe select and replicated write data
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (mem_size)
                    2'b00: begin
                        strb_calc[gi]          = mem_we & (mem_addr[1:0] == 2'(gi));
                        wdata_calc[8*gi +: 8]  = mem_wdata[7:0];
                    end
                    2'b01: begin
                        strb_calc[gi]          = mem_we & (mem_addr[1] == 1'(gi / 2));
                        wdata_calc[8*gi +: 8]  = mem_wdata[8*(gi % 2) +: 8];
                    end
                    default: begin
                        strb_calc[gi]          = mem_we;
                        wdata_calc[8*gi +: 8]  = mem_wdata[8*gi +: 8];
                    end
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)       state_next = REQ;
            REQ:     if (data_addr_ok) state_next = WAIT;
            WAIT:    if (data_data_ok) state_next = DONE;
            DONE:    if (pipe_advance) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Gated by rst so every output is low while reset is held
    always_comb begin
        stallreq = rst & (accept | busy);
        misalign = rst & (state_reg == IDLE) & mem_valid & bad_align;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_wstrb  <= 4'b0000;
            data_addr   <= 32'h0;
            data_wdata  <= 32'h0;
            rdata_out   <= 32'h0;
            rdata_valid <= 1'b0;
            timeout     <= 1'b0;
            wd_cnt_reg  <= '0;
        end else begin
            if (accept) begin
                data_req   <= 1'b1;
                data_wr    <= mem_we;
                data_wstrb <= strb_calc;
                data_addr  <= mem_addr;
                data_wdata <= wdata_calc;
                wd_cnt_reg <= '0;
            end
            if ((state_reg == REQ) && data_addr_ok) begin
                data_req <= 1'b0;
            end
            if (busy) begin
                if (wd_cnt_reg != CNT_MAX) begin
                    wd_cnt_reg <= wd_cnt_reg + 1'b1;
                end
                if (wd_cnt_reg == CNT_LAST) begin
                    timeout <= 1'b1;
                end
            end
            if ((state_reg == WAIT) && data_data_ok) begin
                rdata_valid <= 1'b1;
                if (!data_wr) begin
                    rdata_out <= data_rdata;
                end
            end
            if ((state_reg == DONE) && pipe_advance) begin
                rdata_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, random traffic against a
// transaction-level model, watchdog timeout and reset-in-flight sequences.
module tb_mem_access_ctrl;
    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0, mem_we = 1'b0, pipe_advance = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0, data_rdata = 32'h0;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
    logic        stallreq, data_req, data_wr, rdata_valid, misalign, timeout;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, rdata_out;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(9)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .pipe_advance(pipe_advance), .stallreq(stallreq), .data_req(data_req),
        .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .rdata_out(rdata_out), .rdata_valid(rdata_valid),
        .misalign(misalign), .timeout(timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: one pending access, its phase flags and fields
    bit          m_busy, m_granted, m_done, m_wr, m_timeout;
    logic [3:0]  m_strb;
    logic [31:0] m_addr, m_wdata, m_rdata;
    int          m_wd;

    function automatic bit misaligned(input logic [1:0] size, input logic [31:0] addr);
        int bytes;
        if (size == 2'b11) return 1'b1;
        bytes = 1 << size;
        return (addr % bytes) != 0;
    endfunction

    function automatic logic [3:0] exp_strobe(input logic [1:0] size, input logic [31:0] addr);
        int sh;
        if (size == 2'b00) begin sh = addr % 4;  return 4'(1 << sh); end
        if (size == 2'b01) begin sh = addr & 2;  return 4'(3 << sh); end
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_repl(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] lo;
        if (size == 2'b00) begin lo = w & 32'hFF;   return lo * 32'h0101_0101; end
        if (size == 2'b01) begin lo = w & 32'hFFFF; return lo * 32'h0001_0001; end
        return w;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_granted = 0; m_done = 0; m_wr = 0; m_timeout = 0;
        m_strb = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_wd = 0;
    endtask

    task automatic model_check();
        bit idle, mis, stall;
        #1;
        idle  = !m_busy && !m_done;
        mis   = idle && mem_valid && misaligned(mem_size, mem_addr);
        stall = (idle && mem_valid && !mis) || m_busy;
        check("stallreq", stallreq, stall);
        check("misalign", misalign, mis);
        check("data_req", data_req, m_busy && !m_granted);
        check("data_wr", data_wr, m_wr);
        check("data_wstrb", data_wstrb, m_strb);
        check("data_addr", data_addr, m_addr);
        check("data_wdata", data_wdata, m_wdata);
        check("rdata_out", rdata_out, m_rdata);
        check("rdata_valid", rdata_valid, m_done);
        check("timeout", timeout, m_timeout);
    endtask

    task automatic model_advance();
        if (!m_busy && !m_done) begin
            if (mem_valid && !misaligned(mem_size, mem_addr)) begin
                m_busy = 1; m_granted = 0; m_wd = 0;
                m_wr = mem_we; m_addr = mem_addr;
                m_strb  = mem_we ? exp_strobe(mem_size, mem_addr) : 4'h0;
                m_wdata = exp_repl(mem_size, mem_wdata);
            end
        end else if (m_busy) begin
            m_wd++;
            if (m_wd >= TO) m_timeout = 1;
            if (!m_granted) begin
                if (data_addr_ok) m_granted = 1;
            end else if (data_data_ok) begin
                m_busy = 0; m_done = 1;
                if (!m_wr) m_rdata = data_rdata;
            end
        end else if (pipe_advance) begin
            m_done = 0;
        end
        @(posedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        exp_mis;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic run_txn(input vec_t v);
        int stalls = 0;
        @(negedge clk);
        mem_valid = 1; mem_we = v.we; mem_size = v.size; mem_addr = v.addr; mem_wdata = v.wdata;
        data_addr_ok = 0; data_data_ok = 0; pipe_advance = 0;
        model_check();
        check("tbl_misalign", misalign, v.exp_mis);
        stalls += int'(stallreq);
        model_advance();
        if (v.exp_mis) begin
            @(negedge clk); model_check();
            check("tbl_mis_req", data_req, 1'b0);
            check("tbl_mis_stall", stallreq, 1'b0);
            model_advance();
            @(negedge clk); mem_valid = 0; model_check(); model_advance();
            return;
        end
        @(negedge clk); data_addr_ok = 1; model_check();
        check("tbl_req", data_req, 1'b1);
        check("tbl_wr", data_wr, v.we);
        check("tbl_wstrb", data_wstrb, v.exp_strb);
        check("tbl_wdata", data_wdata, v.exp_wdata);
        check("tbl_addr", data_addr, v.addr);
        stalls += int'(stallreq);
        model_advance();
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1; data_rdata = v.rdata; model_check();
        check("tbl_req_drop", data_req, 1'b0);
        stalls += int'(stallreq);
        model_advance();
        @(negedge clk); data_data_ok = 0; data_rdata = ~v.rdata; model_check();
        check("tbl_rvalid", rdata_valid, 1'b1);
        if (!v.we) check("tbl_rdata", rdata_out, v.rdata);
        stalls += int'(stallreq);
        check("tbl_stall_cycles", stalls, 3);
        model_advance();
        @(negedge clk); pipe_advance = 1; model_check();
        check("tbl_rvalid_hold", rdata_valid, 1'b1);
        model_advance();
        @(negedge clk); pipe_advance = 0; mem_valid = 0; model_check();
        check("tbl_rvalid_clr", rdata_valid, 1'b0);
        model_advance();
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b0, 2'b10, 32'h1000, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0};
        tbl[1]  = '{1'b1, 2'b00, 32'h1003, 32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5};
        tbl[2]  = '{1'b1, 2'b01, 32'h2002, 32'h00001234, 32'h0,        1'b0, 4'b1100, 32'h12341234};
        tbl[3]  = '{1'b0, 2'b10, 32'h1002, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[4]  = '{1'b1, 2'b10, 32'h3000, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 32'hCAFEF00D};
        tbl[5]  = '{1'b1, 2'b00, 32'h0000, 32'h12345678, 32'h0,        1'b0, 4'b0001, 32'h78787878};
        tbl[6]  = '{1'b1, 2'b01, 32'h0010, 32'hFFFFABCD, 32'h0,        1'b0, 4'b0011, 32'hABCDABCD};
        tbl[7]  = '{1'b0, 2'b01, 32'h0005, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[8]  = '{1'b1, 2'b11, 32'h0000, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
        tbl[9]  = '{1'b0, 2'b00, 32'h0007, 32'h0,        32'h11223344, 1'b0, 4'b0000, 32'h0};
        tbl[10] = '{1'b1, 2'b00, 32'h0042, 32'h000000C3, 32'h0,        1'b0, 4'b0100, 32'hC3C3C3C3};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); model_check();
        rst = 1;
        model_advance();

        for (int i = 0; i < 11; i++) run_txn(tbl[i]);

        // Random traffic: new instruction only when the model is idle
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!m_busy && !m_done) begin
                mem_valid = ($urandom % 3) != 0;
                mem_we    = $urandom % 2;
                mem_size  = (($urandom % 8) == 0) ? 2'b11 : 2'($urandom % 3);
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
            data_addr_ok = ($urandom % 3) == 0;
            data_data_ok = ($urandom % 3) == 0;
            data_rdata   = $urandom;
            pipe_advance = $urandom % 2;
            model_check();
            model_advance();
        end
        @(negedge clk);
        mem_valid = 0; data_addr_ok = 0; data_data_ok = 0; pipe_advance = 0;
        for (int c = 0; c < 400 && (m_busy || m_done); c++) begin
            data_addr_ok = 1; data_data_ok = 1; pipe_advance = 1;
            model_check(); model_advance(); @(negedge clk);
        end
        data_addr_ok = 0; data_data_ok = 0; pipe_advance = 0;
        check("drain_idle", int'(m_busy || m_done), 0);
        model_check(); model_advance();

        // Watchdog: addr_ok withheld well past TIMEOUT_CYC, then completes
        @(negedge clk);
        mem_valid = 1; mem_we = 1; mem_size = 2'b10; mem_addr = 32'h4000; mem_wdata = 32'h55AA55AA;
        model_check(); model_advance();
        for (int c = 0; c < TO + 4; c++) begin
            @(negedge clk); model_check(); model_advance();
        end
        @(negedge clk); check("timeout_set", timeout, 1'b1);
        data_addr_ok = 1; model_check(); model_advance();
        @(negedge clk); data_addr_ok = 0; data_data_ok = 1; model_check(); model_advance();
        @(negedge clk); data_data_ok = 0; model_check();
        check("timeout_done", rdata_valid, 1'b1);
        check("timeout_sticky", timeout, 1'b1);
        model_advance();
        @(negedge clk); pipe_advance = 1; model_check(); model_advance();
        @(negedge clk); pipe_advance = 0; mem_valid = 0; model_check(); model_advance();

        // Reset while waiting for data_ok
        @(negedge clk);
        mem_valid = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h1000;
        model_check(); model_advance();
        @(negedge clk); data_addr_ok = 1; model_check(); model_advance();
        @(negedge clk); data_addr_ok = 0; rst = 0;
        #1;
        check("rst_stall", stallreq, 1'b0);
        check("rst_req", data_req, 1'b0);
        check("rst_addr", data_addr, 32'h0);
        check("rst_wdata", data_wdata, 32'h0);
        check("rst_rvalid", rdata_valid, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        model_reset();
        mem_valid = 0;
        @(posedge clk);
        @(negedge clk); rst = 1; data_data_ok = 1; data_rdata = 32'hBAD0BAD0;
        model_check(); model_advance();
        @(negedge clk); data_data_ok = 0; model_check();
        check("stray_ok_rvalid", rdata_valid, 1'b0);
        model_advance();
        run_txn(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
